spi_dac_tx: RTL and testbench

Parametrised, buffered SPI transmit master for DAC and serial-peripheral writes. It replaces the fixed 16-bit, clk-as-sclk writer with the following:
- configurable word width and SCLK divider;
- all four CPOL/CPHA modes;
- multiple chip selects;
- a write FIFO with ready/valid back-pressure.

It sits between the sample pipeline and the off-chip converters. Everything runs in the single `clk` domain, and SCLK is a registered, divided output.

---
 rtl/spi_dac_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_dac_tx.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_tx.sv
// spi_dac_tx: buffered SPI transmit master (write FIFO, CPOL/CPHA, NUM_CS chip selects).
// Optional receive path is compiled in when SPI_DAC_TX_RX_EN is defined.
module spi_dac_tx #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int CS_IDLE    = 2,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CS_W-1:0]   wr_cs,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_sdout,
  output logic              busy,
  output logic [LVL_W-1:0]  fifo_level
`ifdef SPI_DAC_TX_RX_EN
  ,
  input  logic              spi_sdin,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int HALF_W  = $clog2(2 * DATA_W);
  localparam int ENT_W   = CS_W + DATA_W;
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [CS_W:0]     CS_LIMIT  = (CS_W + 1)'(NUM_CS);
  localparam logic              SCLK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [LVL_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CS_W-1:0]    sel_q, sel_d, cs_in;
  logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d, sdout_q, sdout_d;
  logic               ready_q, ready_d, busy_q, busy_d;
  logic               push, pop, sclk_edge, lead_edge, trail_edge, last_half, cs_active;
  logic [ENT_W-1:0]   head;

  // Write handshake: a word is taken on a rising edge with wr_valid && wr_ready;
  // wr_ready is registered and is low exactly while the FIFO is full.
  assign push       = wr_valid && ready_q;
  assign cs_in      = ({1'b0, wr_cs} >= CS_LIMIT) ? '0 : wr_cs;
  assign head       = mem_q[rptr_q];
  assign sclk_edge  = (state_q == S_SHIFT) && (cnt_q == DIV_LAST);
  assign lead_edge  = sclk_edge && !half_q[0];
  assign trail_edge = sclk_edge && half_q[0];
  assign last_half  = (half_q == HALF_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          pop     = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          half_d = half_q + 1'b1;
          if (last_half) state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (count_q != '0) begin
            state_d = S_SETUP;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    shreg_d = shreg_q;
    sel_d   = sel_q;
    sclk_d  = sclk_q;
    sdout_d = sdout_q;
    if (pop) begin
      shreg_d = head[DATA_W-1:0];
      sel_d   = head[ENT_W-1:DATA_W];
      sdout_d = (CPHA == 0) ? head[DATA_W-1] : 1'b0;
    end
    if (sclk_edge) sclk_d = ~sclk_q;
    // CPHA=0 presents the next bit on trailing edges (the final one has nothing left);
    // CPHA=1 presents each bit on its leading edge.
    if ((CPHA == 0) && trail_edge && !last_half) begin
      sdout_d = shreg_q[DATA_W-2];
      shreg_d = shreg_q << 1;
    end
    if ((CPHA != 0) && lead_edge) begin
      sdout_d = shreg_q[DATA_W-1];
      shreg_d = shreg_q << 1;
    end
    if ((state_d == S_IDLE) || (state_d == S_GAP)) sdout_d = 1'b0;

    cs_active = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
    cs_n_d    = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_active && (sel_d == CS_W'(i))) cs_n_d[i] = 1'b0;
    end

    ready_d = (count_d != LVL_FULL);
    busy_d  = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      shreg_q <= '0;
      sel_q   <= '0;
      cs_n_q  <= '1;
      sclk_q  <= SCLK_IDLE;
      sdout_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      shreg_q <= shreg_d;
      sel_q   <= sel_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdout_q <= sdout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cs_in, wr_data};
  end

  assign wr_ready   = ready_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_sclk   = sclk_q;
  assign spi_sdout  = sdout_q;
  assign busy       = busy_q;
  assign fifo_level = count_q;

`ifdef SPI_DAC_TX_RX_EN
  logic [DATA_W-1:0] rx_q, rd_data_q;
  logic              rd_valid_q, sample_edge;

  // Sample on the edge opposite to the one that changes the data line.
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (sample_edge) rx_q <= {rx_q[DATA_W-2:0], spi_sdin};
      rd_valid_q <= (state_q == S_HOLD) && (state_d == S_GAP);
      if ((state_q == S_HOLD) && (state_d == S_GAP)) rd_data_q <= rx_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_spi_dac_tx.sv
// tb_spi_dac_tx: directed checks of spi_dac_tx across four mode instances (CLK_DIV=3,
// NUM_CS=3), one default instance and one NUM_CS=4 instance.
module tb_spi_dac_tx;
  localparam int NI = 6;
  localparam int ID = 4;
  localparam int IM = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_cs = '0;
  logic [NI-1:0] wr_valid = '0;
  logic [NI-1:0] wr_ready, sclk, sdout, busy;
  logic [NI-1:0][3:0] csn;
  logic [NI-1:0][2:0] level;
`ifdef SPI_DAC_TX_RX_EN
  logic [NI-1:0][15:0] rd_data;
  logic [NI-1:0] rd_valid;
`endif
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel = ID;
  logic [3:0] p_csn;
  logic p_sclk, p_sdout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    p_csn   = csn[sel];
    p_sclk  = sclk[sel];
    p_sdout = sdout[sel];
  end

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_dac_tx #(.CLK_DIV(3), .NUM_CS(3), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_cs(wr_cs),
      .wr_valid(wr_valid[g]), .wr_ready(wr_ready[g]), .spi_cs_n(csn[g][2:0]),
      .spi_sclk(sclk[g]), .spi_sdout(sdout[g]), .busy(busy[g]), .fifo_level(level[g])
`ifdef SPI_DAC_TX_RX_EN
      , .spi_sdin(sdout[g]), .rd_data(rd_data[g]), .rd_valid(rd_valid[g])
`endif
    );
    assign csn[g][3] = 1'b1;
  end

  spi_dac_tx u_def (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_cs(wr_cs[0]),
    .wr_valid(wr_valid[ID]), .wr_ready(wr_ready[ID]), .spi_cs_n(csn[ID][0]),
    .spi_sclk(sclk[ID]), .spi_sdout(sdout[ID]), .busy(busy[ID]), .fifo_level(level[ID])
`ifdef SPI_DAC_TX_RX_EN
    , .spi_sdin(sdout[ID]), .rd_data(rd_data[ID]), .rd_valid(rd_valid[ID])
`endif
  );
  assign csn[ID][3:1] = 3'b111;

  spi_dac_tx #(.NUM_CS(4)) u_mcs (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_cs(wr_cs),
    .wr_valid(wr_valid[IM]), .wr_ready(wr_ready[IM]), .spi_cs_n(csn[IM]),
    .spi_sclk(sclk[IM]), .spi_sdout(sdout[IM]), .busy(busy[IM]), .fifo_level(level[IM])
`ifdef SPI_DAC_TX_RX_EN
    , .spi_sdin(sdout[IM]), .rd_data(rd_data[IM]), .rd_valid(rd_valid[IM])
`endif
  );

  // Driver: one write to instance idx; acc is the cycle count just after the accepting edge.
  task automatic write1(input int idx, input logic [15:0] d, input logic [1:0] c, output int acc);
    int t = 0;
    @(negedge clk);
    while (!wr_ready[idx] && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL write_wait inst=%0d ready stayed low, required high", idx);
    end
    wr_data = d;
    wr_cs = c;
    wr_valid[idx] = 1'b1;
    @(negedge clk);
    acc = cyc;
    wr_valid[idx] = 1'b0;
  endtask

  // Monitor: waits for one frame on the probed instance and decodes it on the sample edges.
  task automatic capture(input logic cpol, input logic cpha, output logic [15:0] data,
                         output int edges, output int start_c, output int end_c,
                         output logic [3:0] pat, output logic idle_ok);
    int t = 0;
    logic prev;
    data = '0; edges = 0; start_c = 0; end_c = 0; pat = 4'hF; idle_ok = 1'b1;
    @(negedge clk);
    while (p_csn == 4'hF && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (p_csn == 4'hF) begin
      failures++;
      $display("FAIL frame_start inst=%0d cs_n stayed %h, required a low line", sel, p_csn);
      return;
    end
    start_c = cyc;
    pat = p_csn;
    prev = p_sclk;
    if (p_sclk !== cpol) idle_ok = 1'b0;
    t = 0;
    while (p_csn != 4'hF && t < 400) begin
      if (p_csn !== pat) pat = 4'h0;
      if (p_sclk !== prev) begin
        edges++;
        if ((p_sclk != cpol) != cpha) data = {data[14:0], p_sdout};
        prev = p_sclk;
      end
      @(negedge clk);
      t++;
    end
    end_c = cyc;
    if (p_sclk !== cpol) idle_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (csn[ID] !== 4'hF || csn[IM] !== 4'hF) begin
      failures++;
      $display("FAIL reset_cs got %h/%h required f/f", csn[ID], csn[IM]);
    end
    checks++;
    if (sclk !== 6'b001100) begin
      failures++;
      $display("FAIL reset_sclk got %b required 001100", sclk);
    end
    checks++;
    if (sdout !== '0 || busy !== '0 || wr_ready !== '0) begin
      failures++;
      $display("FAIL reset_flags sdout=%b busy=%b ready=%b required all 0", sdout, busy, wr_ready);
    end
    checks++;
    if (level[ID] !== 3'd0) begin
      failures++;
      $display("FAIL reset_level got %0d required 0", level[ID]);
    end
`ifdef SPI_DAC_TX_RX_EN
    checks++;
    if (rd_valid !== '0 || rd_data[ID] !== 16'h0) begin
      failures++;
      $display("FAIL reset_rd got v=%b d=%h required 0/0", rd_valid, rd_data[ID]);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== '1 || busy !== '0) begin
      failures++;
      $display("FAIL post_reset ready=%b busy=%b required 111111/000000", wr_ready, busy);
    end
  endtask

  task automatic test_single_word();
    int acc, edges, s, e;
    logic [15:0] d;
    logic [3:0] pat;
    logic ok;
    sel = ID;
    write1(ID, 16'hA5C3, 2'd0, acc);
    capture(1'b0, 1'b0, d, edges, s, e, pat, ok);
    checks++;
    if (s - acc != 1) begin
      failures++;
      $display("FAIL single_latency got %0d required 1", s - acc);
    end
    checks++;
    if (e - s != 68) begin
      failures++;
      $display("FAIL single_cs_low got %0d required 68", e - s);
    end
    checks++;
    if (d !== 16'hA5C3 || edges != 32 || pat !== 4'hE || !ok) begin
      failures++;
      $display("FAIL single_frame data=%h edges=%0d cs=%h idle=%b required a5c3/32/e/1", d, edges, pat, ok);
    end
    checks++;
    if (busy[ID] !== 1'b1 || sdout[ID] !== 1'b0) begin
      failures++;
      $display("FAIL single_gap busy=%b sdout=%b required 1/0", busy[ID], sdout[ID]);
    end
    @(negedge clk);
    checks++;
    if (busy[ID] !== 1'b1) begin
      failures++;
      $display("FAIL single_gap2 busy=%b required 1", busy[ID]);
    end
    @(negedge clk);
    checks++;
    if (busy[ID] !== 1'b0 || level[ID] !== 3'd0) begin
      failures++;
      $display("FAIL single_idle busy=%b level=%0d required 0/0", busy[ID], level[ID]);
    end
  endtask

  // Index 3 is out of range for NUM_CS=3 and must drive cs_n[0].
  task automatic test_modes();
    int acc, edges, s, e;
    logic [15:0] d;
    logic [3:0] pat;
    logic ok, cp, ch;
    for (int m = 0; m < 4; m++) begin
      cp = (m >= 2);
      ch = (m % 2 == 1);
      sel = m;
      checks++;
      if (sclk[m] !== cp) begin
        failures++;
        $display("FAIL mode%0d_idle_sclk got %b required %b", m, sclk[m], cp);
      end
      write1(m, 16'h8001, 2'd3, acc);
      capture(cp, ch, d, edges, s, e, pat, ok);
      checks++;
      if (d !== 16'h8001 || edges != 32 || !ok) begin
        failures++;
        $display("FAIL mode%0d_frame data=%h edges=%0d idle=%b required 8001/32/1", m, d, edges, ok);
      end
      checks++;
      if (pat !== 4'hE || e - s != 102) begin
        failures++;
        $display("FAIL mode%0d_cs cs=%h low=%0d required e/102", m, pat, e - s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [6];
    logic [15:0] got [6];
    int starts [6];
    int ends [6];
    int n, t, full_at, reopen_c, edges;
    logic r, ok;
    logic [3:0] pat;
    words = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'hBEEF, 16'h7FFE};
    n = 0; t = 0; full_at = -1; reopen_c = -1;
    sel = ID;
    fork
      begin
        while (n < 6 && t < 2000) begin
          @(negedge clk);
          t++;
          wr_data = words[n];
          wr_cs = 2'd0;
          wr_valid[ID] = 1'b1;
          r = wr_ready[ID];
          if (!r && full_at < 0) begin
            full_at = n;
            checks++;
            if (level[ID] !== 3'd4) begin
              failures++;
              $display("FAIL b2b_full_level got %0d required 4", level[ID]);
            end
          end
          if (r && full_at >= 0 && reopen_c < 0) begin
            reopen_c = cyc;
            checks++;
            if (level[ID] !== 3'd3) begin
              failures++;
              $display("FAIL b2b_reopen_level got %0d required 3", level[ID]);
            end
          end
          @(posedge clk);
          if (r) n++;
        end
        @(negedge clk);
        wr_valid[ID] = 1'b0;
      end
      begin
        for (int f = 0; f < 6; f++) capture(1'b0, 1'b0, got[f], edges, starts[f], ends[f], pat, ok);
      end
    join
    // The first word leaves for SETUP on the edge after it is taken, so the FIFO fills on the fifth accept.
    checks++;
    if (full_at != 5) begin
      failures++;
      $display("FAIL b2b_full_at got %0d accepts required 5", full_at);
    end
    checks++;
    if (reopen_c != starts[1]) begin
      failures++;
      $display("FAIL b2b_reopen got cycle %0d required %0d", reopen_c, starts[1]);
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (got[f] !== words[f]) begin
        failures++;
        $display("FAIL b2b_word%0d got %h required %h", f, got[f], words[f]);
      end
      if (f > 0) begin
        checks++;
        if (starts[f] - starts[f-1] != 70 || starts[f] - ends[f-1] != 2) begin
          failures++;
          $display("FAIL b2b_spacing%0d period=%0d gap=%0d required 70/2", f,
                   starts[f] - starts[f-1], starts[f] - ends[f-1]);
        end
      end
    end
  endtask

  task automatic test_multi_cs();
    logic [1:0] cs_v [4];
    logic [3:0] exp_pat [4];
    logic [3:0] pat [4];
    int starts [4];
    int ends [4];
    int acc, edges;
    logic [15:0] d;
    logic ok;
    cs_v = '{2'd2, 2'd0, 2'd3, 2'd1};
    exp_pat = '{4'b1011, 4'b1110, 4'b0111, 4'b1101};
    sel = IM;
    fork
      begin
        for (int i = 0; i < 4; i++) write1(IM, 16'h5A00 + 16'(i), cs_v[i], acc);
      end
      begin
        for (int f = 0; f < 4; f++) capture(1'b0, 1'b0, d, edges, starts[f], ends[f], pat[f], ok);
      end
    join
    for (int f = 0; f < 4; f++) begin
      checks++;
      if (pat[f] !== exp_pat[f]) begin
        failures++;
        $display("FAIL mcs_pattern%0d got %b required %b", f, pat[f], exp_pat[f]);
      end
      if (f > 0) begin
        checks++;
        if (starts[f] - ends[f-1] < 2) begin
          failures++;
          $display("FAIL mcs_gap%0d got %0d required >=2", f, starts[f] - ends[f-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc, t, rises, bad;
    logic prev;
    t = 0; rises = 0; bad = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) write1(ID, 16'hC0DE + 16'(i), 2'd0, acc);
      end
      begin
        @(negedge clk);
        while (csn[ID][0] !== 1'b0 && t < 300) begin
          @(negedge clk);
          t++;
        end
        prev = sclk[ID];
        while (rises < 8 && t < 300) begin
          @(negedge clk);
          t++;
          if (sclk[ID] === 1'b1 && prev === 1'b0) rises++;
          prev = sclk[ID];
        end
      end
    join
    checks++;
    if (rises != 8 || csn[ID][0] !== 1'b0 || level[ID] !== 3'd2) begin
      failures++;
      $display("FAIL rst_mid_pre rises=%0d cs=%b level=%0d required 8/0/2", rises, csn[ID][0], level[ID]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (csn[ID] !== 4'hF || sclk[ID] !== 1'b0 || sdout[ID] !== 1'b0 || level[ID] !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid_abort cs=%h sclk=%b sdout=%b level=%0d required f/0/0/0",
               csn[ID], sclk[ID], sdout[ID], level[ID]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (csn[ID] !== 4'hF || busy[ID] !== 1'b0 || level[ID] !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got %0d active cycles required 0", bad);
    end
  endtask

`ifdef SPI_DAC_TX_RX_EN
  task automatic test_rx();
    int acc, pulses;
    logic [15:0] got;
    logic prev_cs, edge_ok;
    pulses = 0; got = '0; edge_ok = 1'b1;
    write1(ID, 16'h1234, 2'd0, acc);
    prev_cs = csn[ID][0];
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (rd_valid[ID] === 1'b1) begin
        pulses++;
        got = rd_data[ID];
        if (!(csn[ID][0] === 1'b1 && prev_cs === 1'b0)) edge_ok = 1'b0;
      end
      prev_cs = csn[ID][0];
    end
    checks++;
    if (pulses != 1 || got !== 16'h1234 || !edge_ok) begin
      failures++;
      $display("FAIL rx_loop pulses=%0d data=%h edge=%b required 1/1234/1", pulses, got, edge_ok);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_modes();
    test_back_to_back();
    test_multi_cs();
    test_reset_mid_frame();
`ifdef SPI_DAC_TX_RX_EN
    test_rx();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
